// File: rtl/mult_result_collector_pkg.sv
// rtl/mult_result_collector_pkg.sv - shared widths and collector state for the serial multiplier result path
package mult_result_collector_pkg;

  localparam int MAX_OUT_LEN = 4;
  localparam int BIT_WIDTH   = 8;
  localparam int SEL_W       = $clog2(BIT_WIDTH);
  localparam int ROW_W       = $clog2(MAX_OUT_LEN);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } coll_state_e;

endpackage

// File: rtl/mult_row_deser.sv
// rtl/mult_row_deser.sv - one row's index-addressed serial-to-parallel collect register
module mult_row_deser
  import mult_result_collector_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en_i,
  input  logic [SEL_W-1:0]     wr_idx_i,
  input  logic                 wr_bit_i,
  output logic [BIT_WIDTH-1:0] frame_o
);

  logic [BIT_WIDTH-1:0] collect_q;
  logic [BIT_WIDTH-1:0] collect_d;

  // frame_o already carries this cycle's bit, so the completing beat needs no extra cycle
  always_comb begin
    collect_d           = collect_q;
    collect_d[wr_idx_i] = wr_bit_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      collect_q <= '0;
    end else if (wr_en_i) begin
      collect_q <= collect_d;
    end
  end

  assign frame_o = collect_d;

endmodule

// File: rtl/mult_result_collector.sv
// rtl/mult_result_collector.sv - reassembles serial row results into words and drains them one row at a time
module mult_result_collector
  import mult_result_collector_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [SEL_W-1:0]       in_bit_select,
  input  logic [MAX_OUT_LEN-1:0] in_bits,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BIT_WIDTH-1:0]   out_data,
  output logic [ROW_W-1:0]       out_row,
  output logic                   overflow,
  output logic                   frame_err,
  output logic                   busy
);

  coll_state_e          state_q;
  logic [SEL_W-1:0]     expected_q;
  logic                 frame_err_q;
  logic                 hold_full_q;
  logic [ROW_W-1:0]     drain_row_q;
  logic                 overflow_q;
  logic [BIT_WIDTH-1:0] hold_q  [MAX_OUT_LEN];
  logic [BIT_WIDTH-1:0] frame_w [MAX_OUT_LEN];

  logic idx_zero;
  logic idx_match;
  logic idx_last;
  logic wr_en;
  logic complete;
  logic drain_last;
  logic handshake;
  logic load;

  always_comb begin
    idx_zero   = (in_bit_select == '0);
    idx_match  = (in_bit_select == expected_q);
    idx_last   = (in_bit_select == SEL_W'(BIT_WIDTH - 1));
    // A bad index 0 in COLLECT restarts the frame, so it still writes bit 0
    wr_en      = in_valid && (idx_zero || ((state_q == COLLECT) && idx_match));
    complete   = in_valid && (state_q == COLLECT) && idx_match && idx_last;
    drain_last = (drain_row_q == ROW_W'(MAX_OUT_LEN - 1));
    handshake  = hold_full_q && out_ready;
    load       = complete && (!hold_full_q || (handshake && drain_last));
  end

  for (genvar r = 0; r < MAX_OUT_LEN; r++) begin : g_row
    mult_row_deser u_deser (
      .clk      (clk),
      .rst      (rst),
      .wr_en_i  (wr_en),
      .wr_idx_i (in_bit_select),
      .wr_bit_i (in_bits[r]),
      .frame_o  (frame_w[r])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      expected_q  <= '0;
      frame_err_q <= 1'b0;
    end else if (in_valid) begin
      case (state_q)
        IDLE: begin
          if (idx_zero) begin
            state_q    <= COLLECT;
            expected_q <= SEL_W'(1);
          end else begin
            frame_err_q <= 1'b1;
          end
        end
        COLLECT: begin
          if (idx_match) begin
            if (idx_last) begin
              state_q    <= IDLE;
              expected_q <= '0;
            end else begin
              expected_q <= expected_q + SEL_W'(1);
            end
          end else begin
            frame_err_q <= 1'b1;
            if (idx_zero) begin
              expected_q <= SEL_W'(1);
            end else begin
              state_q    <= IDLE;
              expected_q <= '0;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          expected_q <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full_q <= 1'b0;
      drain_row_q <= '0;
      overflow_q  <= 1'b0;
      for (int r = 0; r < MAX_OUT_LEN; r++) begin
        hold_q[r] <= '0;
      end
    end else begin
      if (handshake) begin
        drain_row_q <= drain_row_q + ROW_W'(1);
        if (drain_last) begin
          hold_full_q <= 1'b0;
        end
      end
      // A load overrides the drain update; a refused frame leaves hold untouched
      if (load) begin
        hold_full_q <= 1'b1;
        drain_row_q <= '0;
        for (int r = 0; r < MAX_OUT_LEN; r++) begin
          hold_q[r] <= frame_w[r];
        end
      end else if (complete) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign out_valid = hold_full_q;
  assign out_row   = drain_row_q;
  assign out_data  = hold_q[drain_row_q];
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q == COLLECT) | hold_full_q;

endmodule

// File: tb/tb_mult_result_collector.sv
// tb/tb_mult_result_collector.sv - vector table plus scoreboard bench for mult_result_collector
module tb_mult_result_collector;
  import mult_result_collector_pkg::*;

  typedef logic [MAX_OUT_LEN-1:0][BIT_WIDTH-1:0] frame_t;
  typedef struct { frame_t in_w; frame_t exp_w; bit gap; } vec_t;
  typedef struct { logic [ROW_W-1:0] row; logic [BIT_WIDTH-1:0] data; } exp_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic [SEL_W-1:0]       in_bit_select;
  logic [MAX_OUT_LEN-1:0] in_bits;
  logic                   out_valid;
  logic                   out_ready;
  logic [BIT_WIDTH-1:0]   out_data;
  logic [ROW_W-1:0]       out_row;
  logic                   overflow;
  logic                   frame_err;
  logic                   busy;

  int   vec_cnt  = 0;
  int   miss_cnt = 0;
  exp_t sb[$];
  vec_t vecs[4];

  mult_result_collector dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_bit_select (in_bit_select),
    .in_bits       (in_bits),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_row       (out_row),
    .overflow      (overflow),
    .frame_err     (frame_err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic frame_t mk(input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] c, input logic [7:0] d);
    frame_t f;
    f[0] = a; f[1] = b; f[2] = c; f[3] = d;
    return f;
  endfunction

  function automatic logic [MAX_OUT_LEN-1:0] plane(input frame_t w, input int i);
    logic [MAX_OUT_LEN-1:0] p;
    for (int r = 0; r < MAX_OUT_LEN; r++) p[r] = w[r][i];
    return p;
  endfunction

  task automatic push_frame(input frame_t e);
    for (int r = 0; r < MAX_OUT_LEN; r++) begin
      exp_t x;
      x.row  = ROW_W'(r);
      x.data = e[r];
      sb.push_back(x);
    end
  endtask

  task automatic beat(input int idx, input logic [MAX_OUT_LEN-1:0] bits);
    @(posedge clk); #1;
    in_valid      = 1'b1;
    in_bit_select = idx[SEL_W-1:0];
    in_bits       = bits;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input frame_t w, input bit gap);
    for (int i = 0; i < BIT_WIDTH; i++) begin
      beat(i, plane(w, i));
      if (gap) idle_cycle();
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_timeout", sb.size(), 0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_err", frame_err, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t e;
      if (sb.size() == 0) begin
        vec_cnt++;
        miss_cnt++;
        $display("FAIL unexpected_word: got row %0d data %0h, want none", out_row, out_data);
      end else begin
        e = sb.pop_front();
        check("out_row", out_row, e.row);
        check("out_data", out_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    frame_t w;
    frame_t a;
    frame_t b;

    rst = 1'b1; in_valid = 1'b0; in_bit_select = '0; in_bits = '0; out_ready = 1'b0;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_row", out_row, 0);
    check("reset_busy", busy, 0);
    check("reset_flags", {overflow, frame_err}, 0);
    @(negedge clk);
    rst = 1'b0;

    // single frame with latency check
    out_ready = 1'b1;
    w = mk(8'h5A, 8'hFF, 8'h00, 8'h81);
    push_frame(w);
    for (int i = 0; i < BIT_WIDTH; i++) beat(i, plane(w, i));
    check("latency_early", out_valid, 0);
    idle_cycle();
    check("latency_valid", out_valid, 1);
    repeat (4) idle_cycle();
    check("single_done", out_valid, 0);
    check("single_flags", {overflow, frame_err}, 0);
    check("single_sb_empty", sb.size(), 0);

    vecs[0] = '{in_w: mk(8'h5A, 8'hFF, 8'h00, 8'h81), exp_w: mk(8'h5A, 8'hFF, 8'h00, 8'h81), gap: 1'b0};
    vecs[1] = '{in_w: mk(8'h7E, 8'h7E, 8'h7E, 8'h7E), exp_w: mk(8'h7E, 8'h7E, 8'h7E, 8'h7E), gap: 1'b1};
    vecs[2] = '{in_w: mk(8'h80, 8'h7F, 8'h01, 8'hFE), exp_w: mk(8'h80, 8'h7F, 8'h01, 8'hFE), gap: 1'b0};
    vecs[3] = '{in_w: mk(8'hC3, 8'h3C, 8'hA5, 8'h5A), exp_w: mk(8'hC3, 8'h3C, 8'hA5, 8'h5A), gap: 1'b1};
    for (int v = 0; v < 4; v++) begin
      push_frame(vecs[v].exp_w);
      send_frame(vecs[v].in_w, vecs[v].gap);
      idle_cycle();
      wait_drain();
      idle_cycle();
      check("vec_idle_valid", out_valid, 0);
      check("vec_idle_busy", busy, 0);
    end

    // backpressure: first word must hold for 5 cycles
    out_ready = 1'b0;
    w = mk(8'h5A, 8'hFF, 8'h00, 8'h81);
    push_frame(w);
    send_frame(w, 1'b0);
    idle_cycle();
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", out_valid, 1);
      check("bp_row", out_row, 0);
      check("bp_data", out_data, 8'h5A);
      idle_cycle();
    end
    out_ready = 1'b1;
    wait_drain();

    // back-to-back: B completes on A's last-row handshake
    a = mk(8'h11, 8'h22, 8'h33, 8'h44);
    b = mk(8'hA1, 8'hB2, 8'hC3, 8'hD4);
    out_ready = 1'b0;
    push_frame(a);
    send_frame(a, 1'b0);
    idle_cycle();
    push_frame(b);
    for (int i = 0; i < BIT_WIDTH - 1; i++) beat(i, plane(b, i));
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle_cycle();
    idle_cycle();
    beat(BIT_WIDTH - 1, plane(b, BIT_WIDTH - 1));
    idle_cycle();
    check("b2b_valid", out_valid, 1);
    check("b2b_row", out_row, 0);
    check("b2b_data", out_data, 8'hA1);
    check("b2b_overflow", overflow, 0);
    wait_drain();

    // overflow: B completes while A is held
    out_ready = 1'b0;
    push_frame(a);
    send_frame(a, 1'b0);
    idle_cycle();
    check("ovf_pre", overflow, 0);
    send_frame(b, 1'b0);
    idle_cycle();
    idle_cycle();
    check("ovf_set", overflow, 1);
    check("ovf_valid", out_valid, 1);
    check("ovf_row", out_row, 0);
    check("ovf_data", out_data, 8'h11);
    out_ready = 1'b1;
    wait_drain();
    idle_cycle();
    check("ovf_no_b", out_valid, 0);

    // sequence error then clean frame
    check("seq_pre", frame_err, 0);
    beat(0, 4'hF); beat(1, 4'h0); beat(2, 4'hF); beat(5, 4'h0);
    idle_cycle();
    check("seq_err", frame_err, 1);
    check("seq_idle", busy, 0);
    w = mk(8'h33, 8'h33, 8'h33, 8'h33);
    push_frame(w);
    send_frame(w, 1'b0);
    idle_cycle();
    wait_drain();
    check("seq_sticky", frame_err, 1);

    // reset mid-frame
    w = mk(8'h96, 8'h69, 8'h0F, 8'hF0);
    for (int i = 0; i < 4; i++) beat(i, plane(w, i));
    check("rst1_busy_pre", busy, 1);
    do_reset();
    push_frame(w);
    send_frame(w, 1'b0);
    idle_cycle();
    wait_drain();

    // reset mid-drain after two rows
    out_ready = 1'b0;
    push_frame(w);
    send_frame(w, 1'b0);
    idle_cycle();
    out_ready = 1'b1;
    idle_cycle();
    idle_cycle();
    out_ready = 1'b0;
    check("rst2_row_pre", out_row, 2);
    check("rst2_valid_pre", out_valid, 1);
    do_reset();
    out_ready = 1'b1;
    w = mk(8'h12, 8'h34, 8'h56, 8'h78);
    push_frame(w);
    send_frame(w, 1'b0);
    idle_cycle();
    wait_drain();
    check("final_flags", {overflow, frame_err}, 0);
    check("final_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
